wb_master_cmd: RTL
==================

WB_MASTER_CMD -- requirements
Module: wb_master_cmd

Interface
REQ-001 Parameter TIMEOUT, default 1024, max cycles waiting for ack (strobe asserted) or ack release before abort.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both high.
REQ-005 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-006 cmd_adr  in  32  start word address.
REQ-007 cmd_count  in  16  word count minus one (0 = 1 word, 65535 = 65536 words).
REQ-008 wr_valid/wr_ready/wr_data  in/out/in  1/1/32  write data stream.
REQ-009 rd_valid/rd_ready/rd_data  out/in/out  1/1/32  read data stream.
REQ-010 done_o  out  1  one-cycle pulse at command end.
REQ-011 err_o  out  1  timeout flag; valid in the done_o cycle, held until the next command is accepted.
REQ-012 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  bus control.
REQ-013 wbm_adr_o, wbm_dat_o  out  32 each; wbm_sel_o  out  4, constant 4'hF.
REQ-014 wbm_ack_i  in  1; wbm_dat_i  in  32; wbm_int_i  in  1.
REQ-015 irq_o  out  1  registered copy of wbm_int_i, one-cycle delay.

Function
REQ-016 FSM states: IDLE, GET_WDATA, STROBE, RELEASE, PUSH_RDATA, DONE.
REQ-017 IDLE: cmd_ready=1 and wbm_cyc_o=0; on accept, latch we/adr/count and clear err_o; go to GET_WDATA if write, else STROBE.
REQ-018 GET_WDATA: wr_ready=1; on wr_valid, latch wr_data into wbm_dat_o, go to STROBE.
REQ-019 STROBE: cyc=stb=1, we=latched we; on ack_i=1, capture wbm_dat_i if read, drop stb next cycle, go to RELEASE.
REQ-020 RELEASE: stb=0, cyc=1; wait for ack_i=0 (slave drops ack only after stb low); then go to PUSH_RDATA if read, else next-word/DONE decision.
REQ-021 PUSH_RDATA: rd_valid=1 with captured word, held stable until rd_ready; then next-word/DONE decision.
REQ-022 Next-word: if remaining count=0 go to DONE, else increment address by 1 (wrap 32'hFFFFFFFF->0), decrement count, go to GET_WDATA or STROBE.
REQ-023 cyc stays 1 across the whole burst including GET_WDATA and PUSH_RDATA stalls; drops only in DONE/IDLE.
REQ-024 Minimum per word: 1 STROBE cycle with ack + 1 RELEASE cycle; stb low at least 1 cycle between words.
REQ-025 Timeout counter resets on entry to STROBE and RELEASE; reaching TIMEOUT sets err_o, drops cyc/stb, goes to DONE, discards remaining words.
REQ-026 DONE: done_o=1 for one cycle, cyc=stb=0, return to IDLE; cmd_ready low in DONE.
REQ-027 ack_i arriving while stb=0 outside RELEASE is ignored.
REQ-028 Stall on wr_valid/rd_ready is unbounded and does not count toward timeout.

Reset
REQ-029 Reset returns FSM to IDLE from any state, abandoning any bus cycle, no done_o pulse.
REQ-030 Reset values: cmd_ready=0 during reset then 1 in IDLE; wr_ready, rd_valid, done_o, err_o, irq_o, cyc, stb, we = 0; adr, dat_o, rd_data = 0; sel = 4'hF.

Structure
REQ-031 State encodings and default TIMEOUT live in shared package wb_master_pkg.
REQ-032 Single module; the timeout counter may be sub-module wb_timeout_cnt (load/enable/expired).

Verification
REQ-033 Read 1 word at 0x10, slave acks after 2 cycles with 0xDEADBEEF, rd_ready=1 -> one rd_valid with 0xDEADBEEF, done_o=1, err_o=0.
REQ-034 Write count=3 at 0xFFFFFFFE, data 1..4 -> bus addresses FFFFFFFE, FFFFFFFF, 0, 1 with data 1..4, stb low >=1 cycle between words.
REQ-035 Slave never acks, TIMEOUT=16 -> cyc drops 16 cycles after stb, done_o with err_o=1, no rd_valid.
REQ-036 Read count=1 with rd_ready held low 10 cycles -> rd_data stable, cyc stays 1, no timeout, second read only after first pop.
REQ-037 Reset asserted mid-STROBE of a 4-word write -> next cycle cyc=stb=0, done_o=0, cmd_ready=1 after reset release.
REQ-038 wbm_int_i pulse 1 cycle -> irq_o pulse 1 cycle, one cycle later, no effect on bus activity.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone command-driven burst master.
// Holds the FSM state encoding, the default abort limit and small address helpers.
package wb_master_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;
  localparam int unsigned ADR_W           = 32;
  localparam int unsigned DAT_W           = 32;
  localparam int unsigned CNT_W           = 16;
  localparam logic [3:0]  WB_SEL_ALL      = 4'hF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GET_WDATA  = 3'd1,
    STROBE     = 3'd2,
    RELEASE    = 3'd3,
    PUSH_RDATA = 3'd4,
    DONE       = 3'd5
  } state_e;

  // Word addresses wrap naturally from all-ones back to zero.
  function automatic logic [ADR_W-1:0] next_word_adr(input logic [ADR_W-1:0] adr);
    return adr + ADR_W'(1);
  endfunction

  // True in the states that keep a bus cycle open.
  function automatic logic burst_active(input state_e st);
    return (st == GET_WDATA) || (st == STROBE) || (st == RELEASE) || (st == PUSH_RDATA);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Cycle counter that flags expiry after LIMIT consecutive enabled cycles.
// load_i restarts the count at zero; the count stops once expired.
module wb_timeout_cnt
  import wb_master_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // Expiry is reached on the LIMIT-th enabled cycle after a load.
  assign expired_o = (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_master_cmd.sv
// Command-driven Wishbone classic burst master: one strobe/ack/release handshake per word,
// with write data pulled from a stream, read data pushed to a stream, and an ack timeout.
module wb_master_cmd
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [CNT_W-1:0] cmd_count_i,

  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [DAT_W-1:0] wr_data_i,

  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [DAT_W-1:0] rd_data_o,

  output logic             done_o,
  output logic             err_o,

  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic [DAT_W-1:0] wbm_dat_i,
  input  logic             wbm_int_i,
  output logic             irq_o
);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DAT_W-1:0]   wdat_q, wdat_d;
  logic [DAT_W-1:0]   rdat_q, rdat_d;
  logic               err_q, err_d;
  logic               irq_q;
  logic               word_end;
  logic               to_expired;
  logic               to_load;
  logic               to_en;

  // Any state change restarts the wait budget; only bus-wait states consume it, so
  // stream stalls in GET_WDATA / PUSH_RDATA never contribute to an abort.
  assign to_load = (state_d != state_q);
  assign to_en   = (state_q == STROBE) || (state_q == RELEASE);

  wb_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .load_i    (to_load),
    .en_i      (to_en),
    .expired_o (to_expired)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    cnt_d       = cnt_q;
    wdat_d      = wdat_q;
    rdat_d      = rdat_q;
    err_d       = err_q;
    word_end    = 1'b0;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    rd_valid_o  = 1'b0;
    done_o      = 1'b0;
    wbm_cyc_o   = burst_active(state_q);
    wbm_stb_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_o = !rst;
        if (cmd_valid_i && !rst) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          cnt_d   = cmd_count_i;
          err_d   = 1'b0;
          state_d = cmd_we_i ? GET_WDATA : STROBE;
        end
      end

      GET_WDATA: begin
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          wdat_d  = wr_data_i;
          state_d = STROBE;
        end
      end

      STROBE: begin
        wbm_stb_o = 1'b1;
        if (wbm_ack_i) begin
          if (!we_q) begin
            rdat_d = wbm_dat_i;
          end
          state_d = RELEASE;
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      RELEASE: begin
        if (!wbm_ack_i) begin
          if (we_q) begin
            word_end = 1'b1;
          end else begin
            state_d = PUSH_RDATA;
          end
        end else if (to_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      PUSH_RDATA: begin
        rd_valid_o = 1'b1;
        word_end   = rd_ready_i;
      end

      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared end-of-word decision for write (after release) and read (after pop).
    if (word_end) begin
      if (cnt_q == '0) begin
        state_d = DONE;
      end else begin
        adr_d   = next_word_adr(adr_q);
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = we_q ? GET_WDATA : STROBE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers drive ports directly, so they are reset too
      // to give defined address/data outputs straight after reset.
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      cnt_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      irq_q   <= wbm_int_i;
    end
  end

  assign wbm_we_o  = wbm_cyc_o & we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;
  assign wbm_sel_o = WB_SEL_ALL;
  assign rd_data_o = rdat_q;
  assign err_o     = err_q;
  assign irq_o     = irq_q;

endmodule
